// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB-Lite codes and the data-phase state encoding for the slave memory.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_WAIT = 2'd1,
    D_ERR1 = 2'd2,
    D_ERR2 = 2'd3
  } dstate_e;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between the master and the slave memory (clock/reset stay outside).
interface ahb_slave_mem_if;
  // Handshake: an address phase is taken on an HCLK edge where HSEL, HREADY and
  // HTRANS[1] are all high; the data phase then lasts until an edge where HREADYOUT=1.
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_slave_mem_array.sv
// DEPTH x 32 word storage: byte-enabled synchronous write, combinational read.
module ahb_slave_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: phase decode, data-phase FSM and byte-lane writes.
// Wait-state insertion is compiled in only when AHB_SLAVE_WAIT_EN is defined.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_slave_mem_if.slave   bus,
  output dstate_e          dbg_state_o
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          ADDR_MSB   = AW + 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

  dstate_e             state_q, state_d;
  logic                act_q, act_d;
  logic [ADDR_MSB:0]   addr_q;
  logic                write_q;
  logic [2:0]          size_q;
  logic                hready_out;
  logic                accept;
  logic                err_new;
  logic                misalign;
  logic [3:0]          be;
  logic                mem_we;
  logic [31:0]         mem_rdata;

  assign hready_out = (state_q == D_IDLE) || (state_q == D_ERR2);

  assign accept = bus.HSEL && bus.HREADY && hready_out &&
                  ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));

  assign misalign = ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0]) ||
                    ((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00));

  // Comparing the full 32-bit address also rejects any set upper bit, so nothing wraps.
  assign err_new = ({1'b0, bus.HADDR} >= ADDR_LIMIT) || (bus.HSIZE > HSIZE_WORD) || misalign;

`ifdef AHB_SLAVE_WAIT_EN
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  logic [3:0] wcnt_q, wcnt_d;
`else
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_STATES);
`endif

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
`ifdef AHB_SLAVE_WAIT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      D_WAIT: begin
`ifdef AHB_SLAVE_WAIT_EN
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = D_IDLE;
`else
        state_d = D_IDLE;
`endif
      end
      D_ERR1:  state_d = D_ERR2;
      default: begin
        state_d = D_IDLE;
        act_d   = 1'b0;
      end
    endcase

    // A new address phase can only land in a ready cycle (D_IDLE or D_ERR2).
    if (accept) begin
      act_d = !err_new;
      if (err_new) begin
        state_d = D_ERR1;
      end else begin
`ifdef AHB_SLAVE_WAIT_EN
        if (WS != 4'd0) begin
          state_d = D_WAIT;
          wcnt_d  = WS;
        end else begin
          state_d = D_IDLE;
        end
`else
        state_d = D_IDLE;
`endif
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= D_IDLE;
      act_q   <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
`ifdef AHB_SLAVE_WAIT_EN
      wcnt_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
`ifdef AHB_SLAVE_WAIT_EN
      wcnt_q  <= wcnt_d;
`endif
      if (accept) begin
        addr_q  <= bus.HADDR[ADDR_MSB:0];
        write_q <= bus.HWRITE;
        size_q  <= bus.HSIZE;
      end
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      HSIZE_BYTE: be[addr_q[1:0]] = 1'b1;
      HSIZE_HALF: be = addr_q[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
  end

  // act_q is only set for legal transfers, so errored beats never reach the array.
  assign mem_we = act_q && write_q && (state_q == D_IDLE);

  ahb_slave_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (HCLK),
    .we_i    (mem_we),
    .be_i    (be),
    .addr_i  (addr_q[ADDR_MSB:2]),
    .wdata_i (bus.HWDATA),
    .rdata_o (mem_rdata)
  );

  assign bus.HRDATA    = (act_q && !write_q && (state_q == D_IDLE)) ? mem_rdata : 32'h0;
  assign bus.HREADYOUT = hready_out;
  assign bus.HRESP     = ((state_q == D_ERR1) || (state_q == D_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign dbg_state_o   = state_q;

  logic unused_burst;
  assign unused_burst = ^bus.HBURST;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem; the wait-state section runs when AHB_SLAVE_WAIT_EN is defined.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

`ifdef AHB_SLAVE_WAIT_EN
  localparam int WS = 3;
`else
  localparam int WS = 0;
`endif
  localparam int DEPTH = 256;

  logic    HCLK;
  logic    HRESETn;
  dstate_e dbg_state;

  ahb_slave_mem_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_slave_mem #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HADDR  = 32'h0;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = HSIZE_WORD;
    bus.HBURST = 3'd0;
    bus.HWDATA = 32'h0;
  endtask

  // One non-pipelined transfer; entered and left just after a rising edge.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int lowc,
                      output logic rsp_low, output logic rsp_end);
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = a;
    bus.HWRITE = wr;
    bus.HSIZE  = sz;
    @(posedge HCLK); #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWDATA = wd;
    lowc    = 0;
    rsp_low = 1'b0;
    @(negedge HCLK);
    while (bus.HREADYOUT !== 1'b1 && lowc < 40) begin
      lowc++;
      rsp_low = rsp_low | bus.HRESP;
      @(negedge HCLK);
    end
    rd      = bus.HRDATA;
    rsp_end = bus.HRESP;
    @(posedge HCLK); #1;
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd);
    logic [31:0] rd;
    int          lowc;
    logic        rl, re;
    xfer(1'b1, a, sz, wd, rd, lowc, rl, re);
    check({tag, "_waits"}, 32'(lowc), 32'(WS));
    check({tag, "_resp"}, {31'b0, re}, {31'b0, HRESP_OKAY});
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int          lowc;
    logic        rl, re;
    exp_q.push_back(exp);
    xfer(1'b0, a, HSIZE_WORD, 32'h0, rd, lowc, rl, re);
    check({tag, "_data"}, rd, exp_q.pop_front());
    check({tag, "_waits"}, 32'(lowc), 32'(WS));
    check({tag, "_resp"}, {31'b0, re}, {31'b0, HRESP_OKAY});
  endtask

  task automatic err_chk(input string tag, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz);
    logic [31:0] rd;
    int          lowc;
    logic        rl, re;
    xfer(wr, a, sz, 32'hBAD0BAD0, rd, lowc, rl, re);
    check({tag, "_lowcycles"}, 32'(lowc), 32'd1);
    check({tag, "_resp_low"}, {31'b0, rl}, 32'd1);
    check({tag, "_resp_high"}, {31'b0, re}, 32'd1);
    check({tag, "_rdata"}, rd, 32'h0);
  endtask

  task automatic idle_cycle(input string tag, input logic sel, input logic [1:0] trans);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HADDR  = 32'h10;
    bus.HWRITE = 1'b1;
    bus.HSIZE  = HSIZE_WORD;
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = 32'h0F0F0F0F;
    @(negedge HCLK);
    check({tag, "_ready"}, {31'b0, bus.HREADYOUT}, 32'd1);
    check({tag, "_resp"}, {31'b0, bus.HRESP}, 32'd0);
    check({tag, "_rdata"}, bus.HRDATA, 32'h0);
    @(posedge HCLK); #1;
  endtask

  // directed sequence
  initial begin
    HRESETn = 1'b0;
    bus_idle();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_ready", {31'b0, bus.HREADYOUT}, 32'd1);
    check("rst_resp", {31'b0, bus.HRESP}, 32'd0);
    check("rst_rdata", bus.HRDATA, 32'h0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, D_IDLE});
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

`ifndef AHB_SLAVE_WAIT_EN
    // back-to-back word write then read of 0x10
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = 32'h10;
    bus.HWRITE = 1'b1;
    bus.HSIZE  = HSIZE_WORD;
    @(posedge HCLK); #1;
    bus.HWDATA = 32'hDEADBEEF;
    bus.HWRITE = 1'b0;
    @(negedge HCLK);
    check("b2b_wr_ready", {31'b0, bus.HREADYOUT}, 32'd1);
    check("b2b_wr_resp", {31'b0, bus.HRESP}, 32'd0);
    check("b2b_wr_rdata", bus.HRDATA, 32'h0);
    @(posedge HCLK); #1;
    bus_idle();
    @(negedge HCLK);
    check("b2b_rd_ready", {31'b0, bus.HREADYOUT}, 32'd1);
    check("b2b_rd_data", bus.HRDATA, 32'hDEADBEEF);
    @(posedge HCLK); #1;
`else
    wr_chk("w10", 32'h10, HSIZE_WORD, 32'hDEADBEEF);
    rd_chk("r10", 32'h10, 32'hDEADBEEF);
`endif

    // byte lanes
    wr_chk("pre20", 32'h20, HSIZE_WORD, 32'h00000000);
    wr_chk("b22", 32'h22, HSIZE_BYTE, 32'hEEABEEEE);
    wr_chk("h20", 32'h20, HSIZE_HALF, 32'hFFFF1234);
    rd_chk("r20", 32'h20, 32'h00AB1234);
    wr_chk("pre24", 32'h24, HSIZE_WORD, 32'hFFFFFFFF);
    wr_chk("b25", 32'h25, HSIZE_BYTE, 32'h00005A00);
    wr_chk("h26", 32'h26, HSIZE_HALF, 32'h9876FFFF);
    rd_chk("r24", 32'h24, 32'h98765AFF);

    // error responses and the highest legal word
    wr_chk("pre00", 32'h0, HSIZE_WORD, 32'hCAFEF00D);
    err_chk("e400", 1'b1, 32'(4 * DEPTH), HSIZE_WORD);
    err_chk("e002", 1'b1, 32'h2, HSIZE_WORD);
    err_chk("esz3", 1'b0, 32'h0, 3'd3);
    err_chk("ehalf1", 1'b1, 32'h1, HSIZE_HALF);
    err_chk("eupper", 1'b1, 32'h80000000, HSIZE_WORD);
    rd_chk("r00", 32'h0, 32'hCAFEF00D);
    wr_chk("w3fc", 32'h3FC, HSIZE_WORD, 32'h13579BDF);
    rd_chk("r3fc", 32'h3FC, 32'h13579BDF);

`ifdef AHB_SLAVE_WAIT_EN
    // wait states: stalled address/control changes must be ignored
    begin
      int lowc;
      logic [31:0] rd;
      wr_chk("pre04", 32'h04, HSIZE_WORD, 32'h04040404);
      bus.HSEL   = 1'b1;
      bus.HTRANS = HTRANS_NONSEQ;
      bus.HADDR  = 32'h04;
      bus.HWRITE = 1'b0;
      bus.HSIZE  = HSIZE_WORD;
      @(posedge HCLK); #1;
      bus.HADDR  = 32'h10;
      bus.HWRITE = 1'b1;
      bus.HWDATA = 32'h66666666;
      lowc = 0;
      @(negedge HCLK);
      while (bus.HREADYOUT !== 1'b1 && lowc < 40) begin
        lowc++;
        bus.HADDR = bus.HADDR + 32'd4;
        @(negedge HCLK);
      end
      rd = bus.HRDATA;
      bus_idle();
      check("ws_lowcycles", 32'(lowc), 32'd3);
      check("ws_data", rd, 32'h04040404);
      @(posedge HCLK); #1;
      rd_chk("ws_r10", 32'h10, 32'hDEADBEEF);
    end
`endif

    // reset asserted inside the data phase of a write
    wr_chk("pre08", 32'h08, HSIZE_WORD, 32'h11223344);
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = 32'h08;
    bus.HWRITE = 1'b1;
    bus.HSIZE  = HSIZE_WORD;
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = 32'h00000055;
    #2 HRESETn = 1'b0;
    #1;
    check("mrst_ready", {31'b0, bus.HREADYOUT}, 32'd1);
    check("mrst_resp", {31'b0, bus.HRESP}, 32'd0);
    check("mrst_rdata", bus.HRDATA, 32'h0);
    check("mrst_state", {30'b0, dbg_state}, {30'b0, D_IDLE});
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    rd_chk("mrst_r08", 32'h08, 32'h11223344);

    // IDLE, BUSY and deselected NONSEQ have no data phase
    idle_cycle("idle", 1'b1, HTRANS_IDLE);
    idle_cycle("busy", 1'b1, HTRANS_BUSY);
    idle_cycle("nosel", 1'b0, HTRANS_NONSEQ);
    rd_chk("idle_r10", 32'h10, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

Word-organised AHB-Lite slave memory that sits directly downstream of the pipelined ALU/register-file AHB master and serves as its single data target. It decodes address and data phases, stores write data with byte lanes, and returns read data. It supports wait-state insertion and a two-cycle ERROR response for illegal accesses. In a single-slave system, HREADYOUT is wired back to both the master's HREADY and this block's HREADY input.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; the legal byte address range is 0 to 4*DEPTH-1.
- WAIT_STATES, 0: wait cycles inserted per data phase, range 0–15. Only used when the wait-state macro is defined.

Ports (clock and reset: HCLK, HRESETn asynchronous active-low):
- HCLK  in  1  system clock, rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; values above 2 are illegal
- HBURST  in  3  accepted and ignored; every beat is decoded independently
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus ready; an address phase is taken only when this is high
- HRDATA  out  32  read data, valid when HREADYOUT=1 in a read data phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- Transfer acceptance: a transfer is accepted on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1. On that edge the block registers HADDR, HWRITE and HSIZE, plus the error flag.
- IDLE and BUSY transfers, and cycles with HSEL=0: no data phase follows. HREADYOUT=1, HRESP=0, no memory effect.
- Error flag: set when HADDR ≥ 4*DEPTH, or HSIZE > 2, or the access is misaligned (halfword with HADDR[0]=1, word with HADDR[1:0]≠0).
- Data-phase FSM states:
  - D_IDLE: HREADYOUT=1, HRESP=0.
  - D_WAIT: HREADYOUT=0, a counter runs down from WAIT_STATES.
  - D_ERR1: HREADYOUT=0, HRESP=1.
  - D_ERR2: HREADYOUT=1, HRESP=1.
- FSM transitions:
  - On an accepted legal transfer: go to D_WAIT if WAIT_STATES>0, otherwise stay in the final data-phase cycle (D_IDLE, ready).
  - D_WAIT, counter reaches 1: the next cycle is the ready cycle.
  - Error flag set: D_ERR1 → D_ERR2 → D_IDLE. If an accepted transfer is presented in D_ERR2, it is registered normally (pipelined).
- Writes: committed on the edge that ends the data phase, i.e. the edge on which HREADYOUT=1. The word index is addr[ADDR_MSB:2].
- Write byte enables:
  - Byte: lane addr[1:0].
  - Halfword: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- Reads: HRDATA is the full addressed word, read combinationally from the array using the registered address. The master extracts the lanes it needs. HRDATA is 0 outside read data phases and during error phases.
- Errored transfers never modify memory.
- Read-after-write to the same word needs no forwarding: the write commits on the same edge that samples the read address.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=D_IDLE, wait counter=0. Memory contents are not reset.
- Zero wait states: address phase at edge N, data phase is cycle N→N+1 with HREADYOUT=1, read data is valid in that cycle. One transfer per cycle with back-to-back pipelining.
- With waits: HREADYOUT is low for exactly WAIT_STATES cycles, then high for one cycle.
- While HREADYOUT=0 the block ignores HTRANS and HADDR, because the address phase is stalled.
- Reset asserted mid-transfer: the in-flight write is dropped and the outputs return to their reset values immediately (asynchronously).
- Upper address bits: HADDR[31:ADDR_MSB+1] must be 0 for an access to be legal. The address never wraps.

## Configuration
- AHB_SLAVE_WAIT_EN:
  - Defined: the WAIT_STATES counter and the D_WAIT state are compiled in.
  - Undefined: every legal data phase completes in one cycle, WAIT_STATES is ignored, and the D_WAIT logic and counter are absent.
- Error responses are identical in both builds.

## Structure
- Package ahb_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ).
  - HSIZE codes (BYTE/HALF/WORD).
  - HRESP codes (OKAY/ERROR).
  - The data-phase state enum.
- Sub-module ahb_slave_mem_array: DEPTH×32 storage with a 4-bit byte-enable synchronous write port and a combinational read port.
- The top level holds the phase decode, the FSM, the wait counter and the lane mask generation.

## Test plan
- Word write then read: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back with WAIT_STATES=0. Required: HRDATA=0xDEADBEEF in the read data phase, HREADYOUT stays high throughout.
- Byte lanes: preload 0x00000000 at 0x20, write byte 0xAB to 0x22 and halfword 0x1234 to 0x20. Required: a read of 0x20 returns 0x00AB1234.
- Wait states: with AHB_SLAVE_WAIT_EN defined and WAIT_STATES=3, a read of 0x04. Required: HREADYOUT low for exactly 3 cycles, data valid on the 4th; HADDR changes while stalled have no effect.
- Errors: a word write to 4*DEPTH and a word access to 0x02. Required for each: HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1; memory unchanged; the next NONSEQ completes OKAY.
- Reset mid-operation: assert HRESETn low during a D_WAIT cycle of a write to 0x08 holding 0x55. Required: HREADYOUT=1 and HRESP=0 immediately; the word at 0x08 keeps its prior value.
- IDLE and BUSY: IDLE and BUSY with HSEL=1, and a NONSEQ with HSEL=0. Required: zero-wait OKAY, no memory change, HRDATA=0.
